// File: rtl/fwd_pkg.sv
// Shared types for the operand-bypass network: history entry layout and register-0 constant.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fwd_pkg;

  // Storage widths of one history entry; the top's XLEN/AW must not exceed these.
  localparam int FWD_XLEN = 32;
  localparam int FWD_AW   = 5;

  // Architectural zero register: never forwarded, never tracked as a valid producer.
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic                valid;
    logic [FWD_AW-1:0]   rd;
    logic [FWD_XLEN-1:0] data;
    logic                pend;
  } hist_entry_t;

endpackage

// File: rtl/fwd_match_prio.sv
// Youngest-match search of the write history for one source address.
// Latency: zero-cycle combinational.
// Backpressure: none; the pend output feeds the top-level stall.
module fwd_match_prio
  import fwd_pkg::*;
#(
  parameter int XLEN  = FWD_XLEN,
  parameter int AW    = FWD_AW,
  parameter int DEPTH = 3
) (
  input  hist_entry_t      hist [DEPTH],
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic             pend,
  output logic [XLEN-1:0]  data
);

  // Scan from entry 0 (youngest) upward; the first match found wins.
  always_comb begin
    hit  = 1'b0;
    pend = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!hit && hist[k].valid && (hist[k].rd == FWD_AW'(addr)) &&
          (addr != AW'(ZERO_REG))) begin
        hit  = 1'b1;
        pend = hist[k].pend;
        data = XLEN'(hist[k].data);
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_net.sv
// N-port operand bypass over a DEPTH-entry in-flight write history; optional stats via FWD_BYPASS_STATS_EN.
// Latency: operands are zero-cycle combinational; writes/fills become visible the cycle after capture.
// Backpressure: stall is raised while any port's youngest match is a pending load; controller holds adv.
module fwd_bypass_net
  import fwd_pkg::*;
#(
  parameter int XLEN    = FWD_XLEN,
  parameter int AW      = FWD_AW,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic                    wr_valid,
  input  logic [AW-1:0]           wr_rd,
  input  logic [XLEN-1:0]         wr_data,
  input  logic                    wr_pend,
  input  logic                    fill_valid,
  input  logic [XLEN-1:0]         fill_data,
  input  logic [NUM_SRC*AW-1:0]   rs_addr,
  input  logic [NUM_SRC*XLEN-1:0] rf_data,
  output logic [NUM_SRC*XLEN-1:0] opnd,
  output logic [NUM_SRC-1:0]      fwd_hit,
  output logic                    stall
`ifdef FWD_BYPASS_STATS_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  hist_entry_t        hist_q [DEPTH];
  hist_entry_t        hist_d [DEPTH];
  logic               fill_done;
  logic [NUM_SRC-1:0] port_stall;

  // Next history: optional shift with new entry 0, then fill the oldest pending entry.
  // The freshly inserted entry 0 is excluded from the fill on an advancing cycle.
  always_comb begin
    fill_done = 1'b0;
    hist_d    = hist_q;
    if (adv) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        hist_d[k] = hist_q[k-1];
      end
      hist_d[0].valid = wr_valid && (wr_rd != AW'(ZERO_REG));
      hist_d[0].rd    = FWD_AW'(wr_rd);
      hist_d[0].data  = FWD_XLEN'(wr_data);
      hist_d[0].pend  = wr_pend;
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (fill_valid && !fill_done && !(adv && (k == 0)) &&
          hist_d[k].valid && hist_d[k].pend) begin
        hist_d[k].data = FWD_XLEN'(fill_data);
        hist_d[k].pend = 1'b0;
        fill_done      = 1'b1;
      end
    end
  end

  // History register; reset clears every entry so nothing forwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      hist_q <= hist_d;
    end
  end

  // One priority matcher per source port; fall back to the register file on a miss.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
    logic            m_hit;
    logic            m_pend;
    logic [XLEN-1:0] m_data;

    fwd_match_prio #(
      .XLEN  (XLEN),
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_match (
      .hist (hist_q),
      .addr (rs_addr[i*AW +: AW]),
      .hit  (m_hit),
      .pend (m_pend),
      .data (m_data)
    );

    assign opnd[i*XLEN +: XLEN] = m_hit ? m_data : rf_data[i*XLEN +: XLEN];
    assign fwd_hit[i]           = m_hit;
    assign port_stall[i]        = m_hit && m_pend;
  end

  assign stall = |port_stall;

`ifdef FWD_BYPASS_STATS_EN
  logic [31:0] hit_inc;

  // Number of ports served from the history this cycle.
  always_comb begin
    hit_inc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_inc = hit_inc + 32'(fwd_hit[i]);
    end
  end

  // Free-running wrap-around counters for forwarded operands and stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (adv) begin
        hit_cnt <= hit_cnt + hit_inc;
      end
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Self-checking bench for fwd_bypass_net: directed scenarios plus randomized traffic vs a queue model.
// Latency: checks combinational outputs on every falling edge.
// Backpressure: stimulus ignores stall to exercise fills and shift-outs under advance.
module tb_fwd_bypass_net;

  localparam int XLEN    = 32;
  localparam int AW      = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;

  logic                    clk;
  logic                    rst_n;
  logic                    adv;
  logic                    wr_valid;
  logic [AW-1:0]           wr_rd;
  logic [XLEN-1:0]         wr_data;
  logic                    wr_pend;
  logic                    fill_valid;
  logic [XLEN-1:0]         fill_data;
  logic [NUM_SRC*AW-1:0]   rs_addr;
  logic [NUM_SRC*XLEN-1:0] rf_data;
  logic [NUM_SRC*XLEN-1:0] opnd;
  logic [NUM_SRC-1:0]      fwd_hit;
  logic                    stall;
`ifdef FWD_BYPASS_STATS_EN
  logic [31:0]             hit_cnt;
  logic [31:0]             stall_cnt;
  bit   [31:0]             m_hit_cnt;
  bit   [31:0]             m_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  fwd_bypass_net #(
    .XLEN    (XLEN),
    .AW      (AW),
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (adv),
    .wr_valid   (wr_valid),
    .wr_rd      (wr_rd),
    .wr_data    (wr_data),
    .wr_pend    (wr_pend),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .rs_addr    (rs_addr),
    .rf_data    (rf_data),
    .opnd       (opnd),
    .fwd_hit    (fwd_hit),
    .stall      (stall)
`ifdef FWD_BYPASS_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the history is a queue of in-flight writes, youngest at the front.
  typedef struct {
    bit            valid;
    bit [AW-1:0]   rd;
    bit [XLEN-1:0] data;
    bit            pend;
  } ment_t;

  ment_t mq[$];

  function automatic void model_reset();
    ment_t e;
    e.valid = 1'b0;
    e.rd    = '0;
    e.data  = '0;
    e.pend  = 1'b0;
    mq.delete();
    for (int k = 0; k < DEPTH; k++) mq.push_back(e);
`ifdef FWD_BYPASS_STATS_EN
    m_hit_cnt   = '0;
    m_stall_cnt = '0;
`endif
  endfunction

  // Expected outputs: youngest matching non-zero register, else register-file data.
  function automatic void model_resolve(output logic [NUM_SRC*XLEN-1:0] o,
                                        output logic [NUM_SRC-1:0] h,
                                        output logic s);
    logic [AW-1:0] a;
    o = '0;
    h = '0;
    s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = rs_addr[i*AW +: AW];
      o[i*XLEN +: XLEN] = rf_data[i*XLEN +: XLEN];
      if (a != 0) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (mq[k].valid && mq[k].rd == a) begin
            o[i*XLEN +: XLEN] = mq[k].data;
            h[i] = 1'b1;
            if (mq[k].pend) s = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  // Model state update on each rising edge, async cleared by reset.
  always @(posedge clk or negedge rst_n) begin : mdl
    ment_t                   e;
    ment_t                   t;
    logic [NUM_SRC*XLEN-1:0] o;
    logic [NUM_SRC-1:0]      h;
    logic                    s;
    if (!rst_n) begin
      model_reset();
    end else begin
      model_resolve(o, h, s);
`ifdef FWD_BYPASS_STATS_EN
      if (adv) m_hit_cnt = m_hit_cnt + 32'($countones(h));
      if (s)   m_stall_cnt = m_stall_cnt + 32'd1;
`endif
      if (adv) begin
        e.valid = wr_valid && (wr_rd != 0);
        e.rd    = wr_rd;
        e.data  = wr_data;
        e.pend  = wr_pend;
        mq.push_front(e);
        void'(mq.pop_back());
      end
      if (fill_valid) begin
        for (int k = DEPTH - 1; k >= (adv ? 1 : 0); k--) begin
          if (mq[k].valid && mq[k].pend) begin
            t      = mq[k];
            t.data = fill_data;
            t.pend = 1'b0;
            mq[k]  = t;
            break;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin : cmp
    logic [NUM_SRC*XLEN-1:0] eo;
    logic [NUM_SRC-1:0]      eh;
    logic                    es;
    if (check_en) begin
      model_resolve(eo, eh, es);
      chk("model_opnd", opnd, eo);
      chk("model_fwd_hit", fwd_hit, eh);
      chk("model_stall", stall, es);
`ifdef FWD_BYPASS_STATS_EN
      chk("model_hit_cnt", hit_cnt, m_hit_cnt);
      chk("model_stall_cnt", stall_cnt, m_stall_cnt);
`endif
    end
  end

  task automatic push(input logic [AW-1:0] rd, input logic [XLEN-1:0] d, input logic p);
    adv      = 1'b1;
    wr_valid = 1'b1;
    wr_rd    = rd;
    wr_data  = d;
    wr_pend  = p;
    @(posedge clk);
    #1;
    adv      = 1'b0;
    wr_valid = 1'b0;
    wr_pend  = 1'b0;
  endtask

  task automatic advance();
    adv      = 1'b1;
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    adv = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n      = 1'b0;
    adv        = 1'b0;
    wr_valid   = 1'b0;
    wr_rd      = '0;
    wr_data    = '0;
    wr_pend    = 1'b0;
    fill_valid = 1'b0;
    fill_data  = '0;
    rs_addr    = '0;
    rf_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Reset state: register file passes through.
    rs_addr = {5'd5, 5'd3};
    rf_data = {32'hA, 32'hB};
    @(negedge clk);
    chk("t1_opnd", opnd, {32'hA, 32'hB});
    chk("t1_hit", fwd_hit, 2'b00);
    chk("t1_stall", stall, 1'b0);

    // Youngest of two writes to the same register wins.
    push(5'd5, 32'h11, 1'b0);
    push(5'd5, 32'h22, 1'b0);
    rs_addr = {5'd3, 5'd5};
    @(negedge clk);
    chk("t2_opnd0", opnd[XLEN-1:0], 32'h22);
    chk("t2_hit", fwd_hit, 2'b01);

    // Register 0 never forwards.
    push(5'd0, 32'hFF, 1'b0);
    rs_addr = {5'd3, 5'd0};
    rf_data = {32'hA, 32'h0};
    @(negedge clk);
    chk("t3_opnd0", opnd[XLEN-1:0], 32'h0);
    chk("t3_hit", fwd_hit, 2'b00);

    // Pending load stalls until its fill arrives.
    push(5'd7, 32'hDEAD, 1'b1);
    rs_addr = {5'd3, 5'd7};
    @(negedge clk);
    chk("t4_stall_on", stall, 1'b1);
    fill_valid = 1'b1;
    fill_data  = 32'h1234;
    @(posedge clk);
    #1;
    fill_valid = 1'b0;
    @(negedge clk);
    chk("t4_stall_off", stall, 1'b0);
    chk("t4_opnd0", opnd[XLEN-1:0], 32'h1234);
    chk("t4_hit", fwd_hit, 2'b01);

    // Oldest entry still forwards; one more advance discards it.
    push(5'd9, 32'h99, 1'b0);
    rs_addr = {5'd3, 5'd9};
    rf_data = {32'hA, 32'hCAFE};
    advance();
    advance();
    @(negedge clk);
    chk("t5_oldest_opnd", opnd[XLEN-1:0], 32'h99);
    chk("t5_oldest_hit", fwd_hit, 2'b01);
    advance();
    @(negedge clk);
    chk("t5_aged_opnd", opnd[XLEN-1:0], 32'hCAFE);
    chk("t5_aged_hit", fwd_hit, 2'b00);

    // Asynchronous reset in the middle of a stall.
    push(5'd7, 32'h77, 1'b1);
    rs_addr = {5'd3, 5'd7};
    @(negedge clk);
    chk("t6_stall_on", stall, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_stall_rst", stall, 1'b0);
    chk("t6_hit_rst", fwd_hit, 2'b00);
    chk("t6_opnd_rst", opnd, {32'hA, 32'hCAFE});
`ifdef FWD_BYPASS_STATS_EN
    chk("t6_hit_cnt", hit_cnt, 32'd0);
    chk("t6_stall_cnt", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic with small register range to force frequent matches.
    for (int n = 0; n < 800; n++) begin
      adv        = ($urandom_range(0, 9) < 6);
      wr_valid   = ($urandom_range(0, 9) < 7);
      wr_rd      = AW'($urandom_range(0, 7));
      wr_data    = $urandom;
      wr_pend    = ($urandom_range(0, 9) < 3);
      fill_valid = ($urandom_range(0, 3) == 0);
      fill_data  = $urandom;
      for (int i = 0; i < NUM_SRC; i++) begin
        rs_addr[i*AW +: AW]     = AW'($urandom_range(0, 7));
        rf_data[i*XLEN +: XLEN] = $urandom;
      end
      @(posedge clk);
      #1;
    end
    adv        = 1'b0;
    fill_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_bypass_net.md
# fwd_bypass_net

Parametrised operand-bypass network with an internal in-flight write history, serving all register-read ports of the decode/issue stage. It tracks the last DEPTH register writes, selects for each source operand the youngest matching value or the register-file value, and raises a stall when the youngest match is a load whose data has not yet returned. It generalises the fixed 3-input, 2-bit-select forwarding multiplexer into a self-tracking, N-port, N-stage unit.

## Interface
- XLEN, 32: data width.
- AW, 5: register address width.
- NUM_SRC, 2: number of source operand ports.
- DEPTH, 3: tracked in-flight writes, minimum 1.
- clk  in  1: clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- adv  in  1: pipeline advance; the history shifts only when adv=1.
- wr_valid  in  1: producer instruction enters the history this advance.
- wr_rd  in  AW: producer destination register.
- wr_data  in  XLEN: producer result; ignored when wr_pend=1.
- wr_pend  in  1: producer is a load; data arrives later via fill.
- fill_valid  in  1: load data return for the oldest pending entry.
- fill_data  in  XLEN: returned load data.
- rs_addr  in  NUM_SRC*AW: packed source addresses; port i uses bits [i*AW +: AW].
- rf_data  in  NUM_SRC*XLEN: packed register-file read data.
- opnd  out  NUM_SRC*XLEN: packed resolved operands.
- fwd_hit  out  NUM_SRC: port i was served from the history.
- stall  out  1: some port's youngest match is pending.

## Operation
- History entries 0 (youngest) to DEPTH-1 (oldest). Each entry holds valid, rd, data, and pend.
- On adv=1, entry k moves to k+1, and entry DEPTH-1 is discarded. Entry 0 loads {wr_valid && wr_rd!=0, wr_rd, wr_data, wr_pend}.
- On adv=0, the history holds. The fill path still operates.
- Fill: fill_valid writes fill_data into the oldest entry with valid && pend and clears its pend. If the same cycle also has adv=1, the fill targets that entry at its post-shift position.
  - A fill arriving when no entry is pending is dropped.
  - A pending entry shifted out before being filled is discarded silently.
- Resolution per port i is combinational from current state and inputs:
  - Find the smallest k with valid[k] && rd[k]==rs_addr_i && rs_addr_i!=0.
  - If a match exists: opnd_i = data[k] and fwd_hit[i]=1.
  - If no match: opnd_i = rf_data_i and fwd_hit[i]=0.
- stall = OR over ports of (match exists && pend[k]). Operands are still driven while stalled. The pipeline controller holds adv=0 while stall=1.
- Register 0 never matches and never enters the history as valid.

## Timing
- A write presented with adv=1 at edge t is visible for forwarding from edge t onward, so it is forwardable to the next instruction with one advance of separation.
- A fill captured at edge t clears stall combinationally in the cycle after t, and the operand carries fill_data in that same cycle.
- Resolution path: rs_addr/rf_data to opnd is zero-cycle combinational, with no registered outputs.
- Reset, asynchronous and applied at any time, including mid-stall:
  - all valid and pend bits = 0; data = 0.
  - Therefore opnd = rf_data, fwd_hit = 0, stall = 0.
- Simultaneous adv, wr_valid and fill: the shift happens first, then the fill is applied to the shifted entry. The new entry 0 is never a fill target in that same cycle.

## Configuration
- FWD_BYPASS_STATS_EN defined adds these outputs:
  - hit_cnt (32 bits): increments by popcount(fwd_hit) on each adv=1 cycle.
  - stall_cnt (32 bits): increments on each stall=1 cycle.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent, with no other behavioural change.

## Structure
- Package fwd_pkg: the hist_entry_t struct (valid, rd, data, pend) and the localparam constant ZERO_REG = 0.
- Sub-module fwd_match_prio: one instance per source port. It takes the history plus one address and returns hit, pend, and data of the youngest match, using a priority search from entry 0 upward.

## Test plan
1. Reset, then rs_addr={5,3} with rf_data={0xA,0xB} -> opnd={0xA,0xB}, fwd_hit=0, stall=0.
2. Push rd=5 data 0x11, then push rd=5 data 0x22, each with adv; read rs=5 -> opnd=0x22 (youngest wins), fwd_hit=1.
3. Push rd=0 data 0xFF; read rs=0 with rf_data 0 -> opnd=0, fwd_hit=0.
4. Push load rd=7 pending and advance; read rs=7 -> stall=1. Hold adv=0, apply fill 0x1234 -> next cycle stall=0 and opnd=0x1234.
5. With DEPTH=3, push rd=9, then advance 3 more times with no writes -> the rs=9 read returns rf_data.
6. Assert rst_n=0 mid-stall -> stall=0 immediately. With FWD_BYPASS_STATS_EN, hit_cnt=stall_cnt=0.
